mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MIPS memory stage. Sits directly downstream of the execute stage.
- Consumes the ALU result, zero flag, branch target, destination register and store data.
- Resolves branches, performs load/store against an internal word-addressed data memory with configurable access latency, and registers results into the MEM/WB boundary.
- Raises `stall` to freeze upstream stages while a multi-cycle access is in flight.

Parameters:
- ADDR_W, 8, word-address width; memory depth is 2**ADDR_W words.
- MEM_LATENCY, 2, memory access wait cycles (0 to 15); 0 means single-cycle access.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EX/MEM slot holds a real instruction (0 = bubble).
- mem_read  in  1  load.
- mem_write  in  1  store.
- branch  in  1  conditional branch (beq).
- mem_to_reg  in  1  writeback selects memory data.
- reg_write  in  1  instruction writes the register file.
- alu_res  in  32  effective address, or ALU result to forward.
- alu_zero  in  1  ALU zero flag.
- rt_data  in  32  store data.
- write_reg  in  5  destination register.
- pc_branch  in  32  branch target.
- stall  out  1  hold upstream stages and inputs stable (combinational).
- pc_src  out  1  take branch (combinational).
- pc_target  out  32  equals pc_branch.
- wb_valid  out  1  MEM/WB slot valid.
- wb_reg_write  out  1  registered reg_write.
- wb_mem_to_reg  out  1  registered mem_to_reg.
- wb_read_data  out  32  load data.
- wb_alu_res  out  32  registered alu_res.
- wb_write_reg  out  5  registered write_reg.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state IDLE, counter 0, all wb_* outputs 0.
  - Memory contents are not cleared by reset.
  - Reset asserted mid-access abandons the access; a pending store is not performed.
- FSM has two states, IDLE and WAIT. A "mem op" is `in_valid & (mem_read | mem_write)`.
- IDLE, non-mem op or bubble:
  - Next edge: `wb_* <= inputs`, `wb_valid <= in_valid`, `wb_read_data <= 0`.
  - 1-cycle latency; stall=0.
- IDLE, mem op, MEM_LATENCY=0:
  - Access at next edge (store writes memory; load registers data into wb_read_data).
  - wb_valid<=1; stall=0.
- IDLE, mem op, MEM_LATENCY>0:
  - stall=1 this cycle.
  - Next edge: latch op fields internally, counter<=MEM_LATENCY-1, state->WAIT, wb_valid<=0.
- WAIT:
  - Inputs are ignored.
  - While counter!=0: stall=1, counter decrements, wb_valid<=0.
  - When counter==0: stall=0; next edge performs the access from the latched fields, loads MEM/WB with wb_valid=1, state->IDLE.
  - Net effect: MEM_LATENCY stall cycles per mem op.
- Branch:
  - `pc_src = (state==IDLE) & in_valid & branch & alu_zero`; pc_target=pc_branch.
  - pc_src is forced 0 in WAIT.
- Addressing:
  - word index = `alu_res[ADDR_W+1:2]`; upper bits ignored, so the address wraps modulo depth.
  - `alu_res[1:0]` is ignored unless the optional feature is enabled.
- mem_read and mem_write both set: treated as a store; wb_read_data<=0.
- Store: wb_read_data<=0; wb_reg_write follows the input (expected 0).

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- With the macro defined:
  - Adds output port `align_err` (1 bit, reset 0).
  - A mem op with `alu_res[1:0]!=0` in IDLE never enters WAIT (stall=0) and never touches memory.
  - Next edge: wb_valid<=1, wb_reg_write<=0, align_err<=1 for exactly one cycle.
- Without the macro: no `align_err` port; low address bits are ignored.

Decomposition:
- Shared header mem_defs.vh holds:
  - FSM state encodings (IDLE=1'b0, WAIT=1'b1);
  - WORD_W=32;
  - REG_ADDR_W=5;
  - MEM_LATENCY counter width (4).
- One natural sub-module: data_memory (parameter ADDR_W; synchronous write; read data captured on the same edge as the access).
  - mem_stage holds the FSM, counter, branch logic and MEM/WB register.

Test Plan:
- Reset mid-WAIT:
  - Store 0xDEADBEEF to 0x10 (L=2), assert rst_n=0 during WAIT -> all outputs 0, state IDLE.
  - Later load 0x10 returns its prior contents, not DEADBEEF.
- Store then load, L=2:
  - Store 0x12345678 to alu_res=0x40 -> stall high 2 cycles, no wb_valid.
  - Load 0x40 -> stall 2 cycles, then wb_valid=1, wb_read_data=0x12345678.
- Back-to-back ALU ops with in_valid=1 and a bubble between:
  - wb_valid sequence 1,0,1; stall never asserts.
  - wb_alu_res/wb_write_reg match inputs one cycle later.
- Branch:
  - branch=1, alu_zero=1, pc_branch=0x104 -> pc_src=1, pc_target=0x104 in the same cycle.
  - branch=1, alu_zero=0 -> pc_src=0.
- Address wrap, ADDR_W=8: store to 0x400 is readable from 0x000.
- MEM_LATENCY=0: load completes next edge with stall never asserted.
- MEM_ALIGN_CHECK_EN: load at 0x42 -> no stall, align_err pulses 1 cycle, wb_valid=1, wb_reg_write=0, memory unchanged.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS memory stage: FSM encoding, widths and the
// latched-operation record.
package mem_stage_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam int WORD_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int CNT_W      = 4;

   typedef struct packed {
      logic                  mem_read;
      logic                  mem_write;
      logic                  mem_to_reg;
      logic                  reg_write;
      logic [WORD_W-1:0]     alu_res;
      logic [WORD_W-1:0]     rt_data;
      logic [REG_ADDR_W-1:0] write_reg;
   } op_t;

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: synchronous write, read data registered on the
// same edge as the access. Contents have no reset so the array maps onto block RAM.
module mem_stage_data_memory
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: branch resolution, multi-cycle load/store FSM and MEM/WB
// register. Optional misaligned-access trap under `MEM_ALIGN_CHECK_EN.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int MEM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic                  branch,
   input  logic                  mem_to_reg,
   input  logic                  reg_write,
   input  logic [WORD_W-1:0]     alu_res,
   input  logic                  alu_zero,
   input  logic [WORD_W-1:0]     rt_data,
   input  logic [REG_ADDR_W-1:0] write_reg,
   input  logic [WORD_W-1:0]     pc_branch,
   output logic                  stall,
   output logic                  pc_src,
   output logic [WORD_W-1:0]     pc_target,
   output logic                  wb_valid,
   output logic                  wb_reg_write,
   output logic                  wb_mem_to_reg,
   output logic [WORD_W-1:0]     wb_read_data,
   output logic [WORD_W-1:0]     wb_alu_res,
   output logic [REG_ADDR_W-1:0] wb_write_reg
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic                  align_err
`endif
);

   localparam bit              MULTI    = (MEM_LATENCY > 0);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY > 0 ? MEM_LATENCY - 1 : 0);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   op_t               op_reg, in_op, acc_op;
   logic              mem_op, misalign, go_wait;
   logic              do_access, load_wb, wb_valid_next;
   logic              mem_we, mem_re, rd_sel_reg;
   logic [WORD_W-1:0] mem_rdata;

   assign in_op  = {mem_read, mem_write, mem_to_reg, reg_write, alu_res, rt_data, write_reg};
   assign mem_op = in_valid & (mem_read | mem_write);

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = (state_reg == IDLE) & mem_op & (alu_res[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign go_wait = mem_op & ~misalign & MULTI;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         op_reg    <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (state_reg == IDLE && go_wait) begin
            op_reg <= in_op;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (go_wait) begin
               state_next = WAIT;
               cnt_next   = CNT_INIT;
            end
         end
         WAIT: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // In IDLE the access (if any) uses live inputs; in WAIT it uses the latched copy.
   always_comb begin
      acc_op        = in_op;
      stall         = 1'b0;
      pc_src        = 1'b0;
      do_access     = 1'b0;
      load_wb       = 1'b0;
      wb_valid_next = 1'b0;
      case (state_reg)
         IDLE: begin
            stall         = go_wait;
            pc_src        = in_valid & branch & alu_zero;
            do_access     = mem_op & ~misalign & ~MULTI;
            load_wb       = ~go_wait;
            wb_valid_next = in_valid;
         end
         WAIT: begin
            acc_op        = op_reg;
            stall         = (cnt_reg != '0);
            do_access     = (cnt_reg == '0);
            load_wb       = (cnt_reg == '0);
            wb_valid_next = 1'b1;
         end
         default: ;
      endcase
      mem_we = do_access & acc_op.mem_write;
      mem_re = do_access & acc_op.mem_read & ~acc_op.mem_write;
   end

   assign pc_target = pc_branch;

   mem_stage_data_memory #(
      .ADDR_W (ADDR_W)
   ) u_dmem (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (acc_op.alu_res[ADDR_W+1:2]),
      .wdata (acc_op.rt_data),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid      <= 1'b0;
         wb_reg_write  <= 1'b0;
         wb_mem_to_reg <= 1'b0;
         wb_alu_res    <= '0;
         wb_write_reg  <= '0;
         rd_sel_reg    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
         align_err     <= 1'b0;
`endif
      end else begin
`ifdef MEM_ALIGN_CHECK_EN
         align_err <= load_wb & misalign;
`endif
         if (load_wb) begin
            wb_valid      <= wb_valid_next;
            wb_reg_write  <= acc_op.reg_write & ~misalign;
            wb_mem_to_reg <= acc_op.mem_to_reg;
            wb_alu_res    <= acc_op.alu_res;
            wb_write_reg  <= acc_op.write_reg;
            rd_sel_reg    <= mem_re;
         end else begin
            wb_valid   <= 1'b0;
            rd_sel_reg <= 1'b0;
         end
      end
   end

   // Memory read register has no reset; this select keeps wb_read_data at 0 otherwise.
   assign wb_read_data = rd_sel_reg ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table vectors, directed corner sequences and random ops
// checked against a word-array reference model. Covers `MEM_ALIGN_CHECK_EN when defined.
module tb_mem_stage;

   localparam int L  = 2;
   localparam int AW = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid, mem_read, mem_write, branch, mem_to_reg, reg_write, alu_zero;
   logic [31:0] alu_res, rt_data, pc_branch;
   logic [4:0]  write_reg;

   logic        stall, pc_src, wb_valid, wb_reg_write, wb_mem_to_reg;
   logic [31:0] pc_target, wb_read_data, wb_alu_res;
   logic [4:0]  wb_write_reg;
   logic        z_stall, z_pc_src, z_wb_valid, z_wb_reg_write, z_wb_mem_to_reg;
   logic [31:0] z_pc_target, z_wb_read_data, z_wb_alu_res;
   logic [4:0]  z_wb_write_reg;
`ifdef MEM_ALIGN_CHECK_EN
   logic        align_err, z_align_err;
`endif

   always #5 clk = ~clk;

   mem_stage #(.ADDR_W(AW), .MEM_LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_read(mem_read),
      .mem_write(mem_write), .branch(branch), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_res(alu_res), .alu_zero(alu_zero),
      .rt_data(rt_data), .write_reg(write_reg), .pc_branch(pc_branch),
      .stall(stall), .pc_src(pc_src), .pc_target(pc_target), .wb_valid(wb_valid),
      .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
      .wb_read_data(wb_read_data), .wb_alu_res(wb_alu_res), .wb_write_reg(wb_write_reg)
`ifdef MEM_ALIGN_CHECK_EN
      , .align_err(align_err)
`endif
   );

   mem_stage #(.ADDR_W(AW), .MEM_LATENCY(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_read(mem_read),
      .mem_write(mem_write), .branch(branch), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_res(alu_res), .alu_zero(alu_zero),
      .rt_data(rt_data), .write_reg(write_reg), .pc_branch(pc_branch),
      .stall(z_stall), .pc_src(z_pc_src), .pc_target(z_pc_target), .wb_valid(z_wb_valid),
      .wb_reg_write(z_wb_reg_write), .wb_mem_to_reg(z_wb_mem_to_reg),
      .wb_read_data(z_wb_read_data), .wb_alu_res(z_wb_alu_res), .wb_write_reg(z_wb_write_reg)
`ifdef MEM_ALIGN_CHECK_EN
      , .align_err(z_align_err)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] ref_mem [256];

   typedef struct {
      logic        v, rd, wr, br, zero, m2r, rw;
      logic [31:0] res, rt, pcb;
      logic [4:0]  wreg;
   } op_s;

   typedef struct {
      op_s  o;
      logic exp_pc_src;
      logic exp_wbv;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic op_s mk(input logic v, input logic rd, input logic wr, input logic br,
                              input logic zero, input logic [31:0] res, input logic [31:0] rt,
                              input logic [31:0] pcb, input logic [4:0] wreg);
      op_s o;
      o.v = v; o.rd = rd; o.wr = wr; o.br = br; o.zero = zero;
      o.m2r = rd & ~wr; o.rw = ~wr;
      o.res = res; o.rt = rt; o.pcb = pcb; o.wreg = wreg;
      return o;
   endfunction

   task automatic drive(input op_s o);
      in_valid = o.v; mem_read = o.rd; mem_write = o.wr; branch = o.br;
      alu_zero = o.zero; mem_to_reg = o.m2r; reg_write = o.rw;
      alu_res = o.res; rt_data = o.rt; pc_branch = o.pcb; write_reg = o.wreg;
   endtask

   // Apply one instruction, hold it through any stall, then check MEM/WB against the model.
   task automatic run_op(input string tag, input op_s o, output logic obs_pc_src);
      int          n;
      logic        s, mop, mis;
      logic [31:0] exp_rd;
      int          exp_stall;
      logic [7:0]  idx;
      mop = o.v & (o.rd | o.wr);
      mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis = mop && (o.res[1:0] != 2'b00);
`endif
      idx    = o.res[9:2];
      exp_rd = 32'h0;
      if (mop && !mis) begin
         if (o.wr) ref_mem[idx] = o.rt;
         else      exp_rd = ref_mem[idx];
      end
      exp_stall = (mop && !mis) ? L : 0;
      drive(o);
      n = 0;
      obs_pc_src = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         s = stall;
         if (c == 0) begin
            obs_pc_src = pc_src;
            chk({tag, " pc_src"}, {31'b0, pc_src}, {31'b0, o.v & o.br & o.zero});
            chk({tag, " pc_target"}, pc_target, o.pcb);
         end
         @(posedge clk);
         #1;
         if (!s) break;
         n++;
         chk({tag, " wb_valid_in_stall"}, {31'b0, wb_valid}, 32'h0);
      end
      chk({tag, " stall_cycles"}, n, exp_stall);
      chk({tag, " wb_valid"}, {31'b0, wb_valid}, {31'b0, o.v});
      chk({tag, " wb_reg_write"}, {31'b0, wb_reg_write}, {31'b0, o.rw & ~mis});
      chk({tag, " wb_mem_to_reg"}, {31'b0, wb_mem_to_reg}, {31'b0, o.m2r});
      chk({tag, " wb_alu_res"}, wb_alu_res, o.res);
      chk({tag, " wb_write_reg"}, {27'b0, wb_write_reg}, {27'b0, o.wreg});
      chk({tag, " wb_read_data"}, wb_read_data, exp_rd);
`ifdef MEM_ALIGN_CHECK_EN
      chk({tag, " align_err"}, {31'b0, align_err}, {31'b0, mis});
`endif
      $display("[TB] %s v=%0d rd=%0d wr=%0d addr=0x%08h stall=%0d rdata=0x%08h",
               tag, o.v, o.rd, o.wr, o.res, n, wb_read_data);
   endtask

   vec_t vt [6];

   initial begin
      logic        pcs;
      op_s         o;
      int          k;
      logic [31:0] saved;

      drive(mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0));
      repeat (3) @(posedge clk);
      #1;
      chk("reset wb_valid", {31'b0, wb_valid}, 32'h0);
      chk("reset wb_read_data", wb_read_data, 32'h0);
      chk("reset wb_alu_res", wb_alu_res, 32'h0);
      chk("reset stall", {31'b0, stall}, 32'h0);
      chk("reset pc_src", {31'b0, pc_src}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill every word so the model knows the full memory contents.
      for (int i = 0; i < 256; i++) begin
         run_op($sformatf("init%0d", i),
                mk(1, 0, 1, 0, 0, 32'(i) << 2, 32'h5A00_0000 ^ (32'(i) * 32'h0101_0101), 32'h0, 5'd0), pcs);
      end

      vt[0] = '{mk(1, 0, 0, 0, 0, 32'h1111_1111, 32'h0, 32'h0, 5'd3), 1'b0, 1'b1};
      vt[1] = '{mk(0, 0, 0, 0, 0, 32'h2222_2222, 32'h0, 32'h0, 5'd4), 1'b0, 1'b0};
      vt[2] = '{mk(1, 0, 0, 0, 0, 32'h3333_3333, 32'h0, 32'h0, 5'd5), 1'b0, 1'b1};
      vt[3] = '{mk(1, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0000_0104, 5'd0), 1'b1, 1'b1};
      vt[4] = '{mk(1, 0, 0, 1, 0, 32'h7, 32'h0, 32'h0000_0200, 5'd0), 1'b0, 1'b1};
      vt[5] = '{mk(0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0000_0300, 5'd0), 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         run_op($sformatf("vec%0d", i), vt[i].o, pcs);
         chk($sformatf("vec%0d tbl_pc_src", i), {31'b0, pcs}, {31'b0, vt[i].exp_pc_src});
         chk($sformatf("vec%0d tbl_wb_valid", i), {31'b0, wb_valid}, {31'b0, vt[i].exp_wbv});
      end

      run_op("st40", mk(1, 0, 1, 0, 0, 32'h40, 32'h1234_5678, 32'h0, 5'd0), pcs);
      run_op("ld40", mk(1, 1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 5'd8), pcs);
      chk("ld40 const", wb_read_data, 32'h1234_5678);

      run_op("st400", mk(1, 0, 1, 0, 0, 32'h400, 32'hA5A5_0400, 32'h0, 5'd0), pcs);
      run_op("ld000", mk(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd9), pcs);
      chk("wrap const", wb_read_data, 32'hA5A5_0400);

      // Reset during WAIT must abandon the pending store.
      saved = ref_mem[4];
      drive(mk(1, 0, 1, 0, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 5'd0));
      @(negedge clk);
      chk("rstwait stall_pre", {31'b0, stall}, 32'h1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rstwait stall", {31'b0, stall}, 32'h0);
      chk("rstwait pc_src", {31'b0, pc_src}, 32'h0);
      chk("rstwait wb_valid", {31'b0, wb_valid}, 32'h0);
      chk("rstwait wb_reg_write", {31'b0, wb_reg_write}, 32'h0);
      chk("rstwait wb_mem_to_reg", {31'b0, wb_mem_to_reg}, 32'h0);
      chk("rstwait wb_read_data", wb_read_data, 32'h0);
      chk("rstwait wb_alu_res", wb_alu_res, 32'h0);
      chk("rstwait wb_write_reg", {27'b0, wb_write_reg}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op("ld10", mk(1, 1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 5'd2), pcs);
      chk("ld10 prior", wb_read_data, saved);

`ifdef MEM_ALIGN_CHECK_EN
      run_op("ld42", mk(1, 1, 0, 0, 0, 32'h42, 32'h0, 32'h0, 5'd6), pcs);
      run_op("st41", mk(1, 0, 1, 0, 0, 32'h41, 32'hBAD0_BAD0, 32'h0, 5'd0), pcs);
      run_op("ld40b", mk(1, 1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 5'd6), pcs);
      chk("align mem_unchanged", wb_read_data, 32'h1234_5678);
`endif

      for (int i = 0; i < 80; i++) begin
         k = int'($urandom_range(0, 4));
         o = mk(k != 0, k == 2 || k == 4, k == 3 || k == 4, 1'b0, 1'b0,
                $urandom, $urandom, $urandom, 5'($urandom));
         if (k <= 1) begin
            o.br   = 1'($urandom);
            o.zero = 1'($urandom);
            o.rw   = 1'($urandom);
            o.m2r  = 1'($urandom);
         end
         if ($urandom_range(0, 3) != 0) o.res[1:0] = 2'b00;
         run_op($sformatf("rnd%0d", i), o, pcs);
      end

      // Zero-latency instance: store then load, each completing on the next edge.
      drive(mk(1, 0, 1, 0, 0, 32'h80, 32'hCAFE_F00D, 32'h0, 5'd0));
      @(negedge clk);
      chk("l0 st stall", {31'b0, z_stall}, 32'h0);
      @(posedge clk);
      #1;
      chk("l0 st wb_valid", {31'b0, z_wb_valid}, 32'h1);
      chk("l0 st wb_read_data", z_wb_read_data, 32'h0);
      $display("[TB] l0_store addr=0x00000080 wb_valid=%0d", z_wb_valid);
      drive(mk(1, 1, 0, 0, 0, 32'h80, 32'h0, 32'h0, 5'd7));
      @(negedge clk);
      chk("l0 ld stall", {31'b0, z_stall}, 32'h0);
      @(posedge clk);
      #1;
      chk("l0 ld wb_valid", {31'b0, z_wb_valid}, 32'h1);
      chk("l0 ld wb_read_data", z_wb_read_data, 32'hCAFE_F00D);
      chk("l0 ld wb_reg_write", {31'b0, z_wb_reg_write}, 32'h1);
      $display("[TB] l0_load addr=0x00000080 rdata=0x%08h", z_wb_read_data);
      drive(mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0));
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
